// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character LCD sequencer.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWRUP_WAIT,
    INIT_LOAD,
    SETUP,
    EN_HIGH,
    HOLD,
    EXEC_WAIT,
    IDLE
  } lcd_state_e;

  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_HOME      = 8'h02;
  localparam logic [7:0] CMD_HOME_ALT  = 8'h03;
  localparam logic [7:0] FUNC_SET_8B2L = 8'h38;
  localparam logic [7:0] DISP_ON       = 8'h0C;
  localparam logic [7:0] ENTRY_INC     = 8'h06;

  localparam int unsigned LCD_INIT_LEN = 4;
  localparam logic [7:0] LCD_INIT_SEQ [LCD_INIT_LEN] =
    '{FUNC_SET_8B2L, DISP_ON, CMD_CLEAR, ENTRY_INC};

  // Clear and home commands need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == CMD_CLEAR) || (data == CMD_HOME) || (data == CMD_HOME_ALT));
  endfunction

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_timer.sv
// Loadable down-counter shared by all timed states of the LCD sequencer.
module lcd_timer
  import lcd_pkg::*;
#(
  parameter int unsigned    W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] cnt_q;

  // Load takes priority; otherwise count down and stick at zero.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q <= RST_VAL;
    end else if (i_load) begin
      cnt_q <= i_load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 write-only bus sequencer: power-up init, then one byte per
// valid/ready request with generated setup/EN/hold/execution timing.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned T_PWRUP = 750000,
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_EN    = 25,
  parameter int unsigned T_HOLD  = 2,
  parameter int unsigned T_EXEC  = 2000,
  parameter int unsigned T_CLEAR = 82000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic       i_req_rs,
  input  logic [7:0] i_req_data,
  output logic       o_busy,
  output logic       o_init_done,
  output logic       o_lcd_on,
  output logic       o_lcd_en,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic [7:0] o_lcd_data
);

  localparam int unsigned T_MAX = umax(umax(umax(T_PWRUP, T_SETUP), umax(T_EN, T_HOLD)),
                                       umax(T_EXEC, T_CLEAR));
  localparam int unsigned TW    = $clog2(T_MAX + 1);

  lcd_state_e  state_q, state_d;
  logic        en_q, en_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;
  logic        rdy_q, rdy_d;
  logic        done_q, done_d;
  logic        on_q;
  logic [2:0]  idx_q, idx_d;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_zero;

  // The timer resets to T_PWRUP, not T_PWRUP-1: the reset-release cycle
  // precedes power-on, so the power-up wait is counted from o_lcd_on rising.
  lcd_timer #(
    .W       (TW),
    .RST_VAL (TW'(T_PWRUP))
  ) u_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (tmr_load),
    .i_load_val (tmr_val),
    .o_zero     (tmr_zero)
  );

  // State and registered bus outputs.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= PWRUP_WAIT;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
      on_q    <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
      on_q    <= 1'b1;
      idx_q   <= idx_d;
    end
  end

  // Next-state, timer reload and next output values.
  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    rs_d     = rs_q;
    data_d   = data_q;
    rdy_d    = rdy_q;
    done_d   = done_q;
    idx_d    = idx_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      PWRUP_WAIT: begin
        if (tmr_zero) state_d = INIT_LOAD;
      end
      INIT_LOAD: begin
        rs_d     = 1'b0;
        data_d   = LCD_INIT_SEQ[idx_q[1:0]];
        idx_d    = idx_q + 3'd1;
        state_d  = SETUP;
        tmr_load = 1'b1;
        tmr_val  = TW'(T_SETUP - 1);
      end
      SETUP: begin
        if (tmr_zero) begin
          state_d  = EN_HIGH;
          en_d     = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = TW'(T_EN - 1);
        end
      end
      EN_HIGH: begin
        if (tmr_zero) begin
          state_d  = HOLD;
          en_d     = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = TW'(T_HOLD - 1);
        end
      end
      HOLD: begin
        if (tmr_zero) begin
          state_d  = EXEC_WAIT;
          tmr_load = 1'b1;
          tmr_val  = is_long_cmd(rs_q, data_q) ? TW'(T_CLEAR - 1) : TW'(T_EXEC - 1);
        end
      end
      EXEC_WAIT: begin
        if (tmr_zero) begin
          if (done_q) begin
            state_d = IDLE;
            rdy_d   = 1'b1;
          end else if (idx_q == 3'(LCD_INIT_LEN)) begin
            state_d = IDLE;
            rdy_d   = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = INIT_LOAD;
          end
        end
      end
      IDLE: begin
        if (i_req_valid && rdy_q) begin
          rs_d     = i_req_rs;
          data_d   = i_req_data;
          rdy_d    = 1'b0;
          state_d  = SETUP;
          tmr_load = 1'b1;
          tmr_val  = TW'(T_SETUP - 1);
        end
      end
      default: begin
        state_d = PWRUP_WAIT;
      end
    endcase
  end

  // Every phase must last at least one cycle.
  param_legal: assert property (@(posedge i_clk)
    (T_PWRUP >= 1) && (T_SETUP >= 1) && (T_EN >= 1) &&
    (T_HOLD >= 1) && (T_EXEC >= 1) && (T_CLEAR >= 1));

  assign o_req_ready = rdy_q;
  assign o_busy      = ~rdy_q;
  assign o_init_done = done_q;
  assign o_lcd_on    = on_q;
  assign o_lcd_en    = en_q;
  assign o_lcd_rs    = rs_q;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_data  = data_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl: the driver pushes expected EN pulses,
// the monitor pops one per EN rise and checks pins and timing.
module tb_lcd_ctrl;

  localparam int unsigned P_PWRUP = 10;
  localparam int unsigned P_SETUP = 2;
  localparam int unsigned P_EN    = 4;
  localparam int unsigned P_HOLD  = 2;
  localparam int unsigned P_EXEC  = 8;
  localparam int unsigned P_CLEAR = 20;

  logic       i_clk;
  logic       i_reset;
  logic       i_req_valid;
  logic       o_req_ready;
  logic       i_req_rs;
  logic [7:0] i_req_data;
  logic       o_busy;
  logic       o_init_done;
  logic       o_lcd_on;
  logic       o_lcd_en;
  logic       o_lcd_rs;
  logic       o_lcd_rw;
  logic [7:0] o_lcd_data;

  lcd_ctrl #(
    .T_PWRUP (P_PWRUP),
    .T_SETUP (P_SETUP),
    .T_EN    (P_EN),
    .T_HOLD  (P_HOLD),
    .T_EXEC  (P_EXEC),
    .T_CLEAR (P_CLEAR)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_rs    (i_req_rs),
    .i_req_data  (i_req_data),
    .o_busy      (o_busy),
    .o_init_done (o_init_done),
    .o_lcd_on    (o_lcd_on),
    .o_lcd_en    (o_lcd_en),
    .o_lcd_rs    (o_lcd_rs),
    .o_lcd_rw    (o_lcd_rw),
    .o_lcd_data  (o_lcd_data)
  );

  // One expected EN pulse. nxt: 1 = next event is another EN rise,
  // 2 = next event is o_req_ready rising; gap counts edges from EN fall.
  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         rise_at;
    int         nxt;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   n_total  = 0;
  int   n_pass   = 0;
  int   pushed   = 0;
  int   rises    = 0;

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    forever begin
      @(posedge i_clk);
      cyc++;
      if (cyc > 20000) begin
        check("global_timeout", 0, 1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
      end
    end
  end

  // Monitor: pops one expectation per EN rise, times pulse and gaps.
  initial begin
    logic en_prev  = 1'b0;
    logic rdy_prev = 1'b0;
    int   waiting  = 0;
    int   pend_gap = 0;
    int   rise_cyc = 0;
    int   fall_cyc = 0;
    exp_t cur;
    cur = '{1'b0, 8'h00, -1, 0, 0};
    forever begin
      @(negedge i_clk);
      if (!i_reset) begin
        en_prev  = 1'b0;
        rdy_prev = 1'b0;
        waiting  = 0;
      end else begin
        if (o_lcd_en && !en_prev) begin
          rises++;
          if (waiting == 1) check("init_gap", cyc - fall_cyc, pend_gap);
          else if (waiting == 2) check("en_before_ready", 0, 1);
          waiting = 0;
          if (exp_q.size() == 0) begin
            check("unexpected_en_pulse", 0, 1);
          end else begin
            cur = exp_q.pop_front();
            check("pulse_data", o_lcd_data, cur.data);
            check("pulse_rs", o_lcd_rs, cur.rs);
            check("pulse_rw", o_lcd_rw, 0);
            if (cur.rise_at >= 0) check("en_rise_time", cyc, cur.rise_at);
          end
          rise_cyc = cyc;
        end
        if (!o_lcd_en && en_prev) begin
          check("en_width", cyc - rise_cyc, P_EN);
          check("hold_data", o_lcd_data, cur.data);
          waiting  = cur.nxt;
          pend_gap = cur.gap;
          fall_cyc = cyc;
        end
        if (o_req_ready && !rdy_prev) begin
          if (waiting == 2) check("ready_gap", cyc - fall_cyc, pend_gap);
          else check("unexpected_ready", 0, 1);
          waiting = 0;
        end
        en_prev  = o_lcd_en;
        rdy_prev = o_req_ready;
      end
    end
  end

  task automatic wait_ready(input int bound);
    for (int n = 0; n < bound; n++) begin
      @(negedge i_clk);
      if (o_req_ready) return;
    end
    check("ready_timeout", 0, 1);
  endtask

  // Release reset and expect the four-byte init sequence.
  task automatic run_init();
    int c0;
    @(negedge i_clk);
    i_reset = 1'b1;
    c0 = cyc;
    for (int n = 0; n < 30; n++) begin
      @(negedge i_clk);
      if (o_lcd_on) break;
    end
    check("lcd_on_delay", cyc - c0, 1);
    check("init_done_clear", o_init_done, 0);
    exp_q.push_back('{1'b0, 8'h38, cyc + 13, 1, 13});
    exp_q.push_back('{1'b0, 8'h0C, -1, 1, 13});
    exp_q.push_back('{1'b0, 8'h01, -1, 1, 25});
    exp_q.push_back('{1'b0, 8'h06, -1, 2, 10});
    pushed += 4;
    wait_ready(300);
    check("init_done_set", o_init_done, 1);
  endtask

  // Present one request; keep=1 leaves valid high with junk data while busy.
  task automatic send(input logic rs, input logic [7:0] d, input int gap,
                      input bit keep, output int k);
    int n;
    for (n = 0; n < 400; n++) begin
      @(negedge i_clk);
      if (o_req_ready) break;
      if (keep) begin
        i_req_data = d ^ 8'hA5 ^ 8'(n);
        i_req_rs   = ~rs;
      end
    end
    if (!o_req_ready) begin
      check("req_timeout", 0, 1);
      i_req_valid = 1'b0;
      k = -1;
      return;
    end
    i_req_valid = 1'b1;
    i_req_rs    = rs;
    i_req_data  = d;
    k = cyc + 1;
    exp_q.push_back('{rs, d, k + 2, 2, gap});
    pushed++;
    @(negedge i_clk);
    check("capture_data", o_lcd_data, d);
    check("capture_rs", o_lcd_rs, rs);
    check("ready_drop", o_req_ready, 0);
    check("busy_set", o_busy, 1);
    if (keep) begin
      i_req_data = ~d;
      i_req_rs   = ~rs;
    end else begin
      i_req_valid = 1'b0;
    end
  endtask

  initial begin
    int k, k1, k2, k3;
    i_reset     = 1'b0;
    i_req_valid = 1'b0;
    i_req_rs    = 1'b0;
    i_req_data  = 8'h00;
    repeat (3) @(negedge i_clk);
    check("rst_ready", o_req_ready, 0);
    check("rst_busy", o_busy, 1);
    check("rst_done", o_init_done, 0);
    check("rst_on", o_lcd_on, 0);
    check("rst_en", o_lcd_en, 0);
    check("rst_rs", o_lcd_rs, 0);
    check("rst_rw", o_lcd_rw, 0);
    check("rst_data", o_lcd_data, 0);

    run_init();

    // Directed requests: (rs, data, ready gap after EN fall = T_HOLD + wait)
    send(1'b1, 8'h41, 10, 1'b0, k);
    send(1'b0, 8'h01, 22, 1'b0, k);
    send(1'b1, 8'h01, 10, 1'b0, k);
    send(1'b0, 8'h02, 22, 1'b0, k);
    send(1'b0, 8'h03, 22, 1'b0, k);
    send(1'b0, 8'h04, 10, 1'b0, k);
    send(1'b0, 8'h00, 10, 1'b0, k);

    // Valid held high with changing data while busy.
    send(1'b1, 8'h48, 10, 1'b1, k1);
    send(1'b1, 8'h49, 10, 1'b1, k2);
    send(1'b0, 8'h02, 22, 1'b1, k3);
    i_req_valid = 1'b0;
    check("throughput_1", k2 - k1, 17);
    check("throughput_2", k3 - k2, 17);

    // Reset in the middle of an EN pulse.
    send(1'b1, 8'h55, 10, 1'b0, k);
    for (int n = 0; n < 20; n++) begin
      @(negedge i_clk);
      if (o_lcd_en) break;
    end
    check("en_seen_before_reset", o_lcd_en, 1);
    @(posedge i_clk);
    #2;
    i_reset = 1'b0;
    #1;
    check("async_rst_en", o_lcd_en, 0);
    check("async_rst_data", o_lcd_data, 0);
    check("async_rst_rs", o_lcd_rs, 0);
    check("async_rst_on", o_lcd_on, 0);
    check("async_rst_done", o_init_done, 0);
    check("async_rst_busy", o_busy, 1);
    repeat (2) @(negedge i_clk);

    run_init();
    send(1'b1, 8'h4F, 10, 1'b0, k);
    wait_ready(100);
    @(negedge i_clk);
    check("queue_empty", exp_q.size(), 0);
    check("pulse_count", rises, pushed);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lcd_ctrl.md
# lcd_ctrl

Hardware sequencer for the HD44780-compatible character LCD on the board's LCD header. It is the consuming end of the LSU's LCD output register. The LSU hands it one command or data byte per request over a valid/ready handshake. The block generates the bus timing (RS/RW setup, EN pulse, hold, execution wait) itself, so software no longer bit-bangs EN. After reset it runs the power-up initialisation on its own before accepting requests.

## Interface
Parameters (all in clock cycles; defaults assume 50 MHz):
- T_PWRUP, 750000, wait after reset release before the first init command (15 ms)
- T_SETUP, 2, RS/RW/DATA stable before EN rises
- T_EN, 25, EN high width (500 ns)
- T_HOLD, 2, DATA/RS held after EN falls
- T_EXEC, 2000, execution wait for normal commands and data (40 us)
- T_CLEAR, 82000, execution wait for clear (0x01) and home (0x02/0x03) commands with RS=0 (1.64 ms)

Ports:
- i_clk, in, 1, the block's single clock
- i_reset, in, 1, asynchronous reset, active-low
- i_req_valid, in, 1, request present
- o_req_ready, out, 1, block can accept a request
- i_req_rs, in, 1, 0 = command, 1 = data
- i_req_data, in, 8, byte to write
- o_busy, out, 1, inverse of o_req_ready
- o_init_done, out, 1, sticky; set when the init sequence completes
- o_lcd_on, out, 1, LCD power/backlight enable
- o_lcd_en, out, 1, LCD EN strobe
- o_lcd_rs, out, 1, LCD RS
- o_lcd_rw, out, 1, LCD R/W; always 0 (write-only)
- o_lcd_data, out, 8, LCD DB[7:0]

## Operation
- FSM states: PWRUP_WAIT, INIT_LOAD, SETUP, EN_HIGH, HOLD, EXEC_WAIT, IDLE.
- Reset state is PWRUP_WAIT. Reset values: o_req_ready=0, o_busy=1, o_init_done=0, o_lcd_on=0, o_lcd_en=0, o_lcd_rs=0, o_lcd_rw=0, o_lcd_data=0.
- PWRUP_WAIT:
  - o_lcd_on is set to 1 on the first clock edge after reset is released.
  - The state lasts T_PWRUP cycles, then goes to INIT_LOAD.
- INIT_LOAD:
  - Loads the next init byte with RS=0, in order 0x38, 0x0C, 0x01, 0x06, then goes to SETUP.
  - After the 4th byte has finished EXEC_WAIT, o_init_done is set and the FSM goes to IDLE.
- IDLE:
  - o_req_ready=1.
  - On i_req_valid && o_req_ready at a clock edge, i_req_rs and i_req_data are captured into the output registers and the FSM goes to SETUP.
- SETUP: lasts T_SETUP cycles with EN=0.
- EN_HIGH: lasts T_EN cycles with EN=1.
- HOLD: lasts T_HOLD cycles with EN=0.
- EXEC_WAIT:
  - Lasts T_CLEAR cycles if the byte is a clear/home command (RS=0 and data 0x01, 0x02 or 0x03); otherwise T_EXEC cycles.
  - Then returns to INIT_LOAD during init, or to IDLE otherwise.
- o_lcd_data and o_lcd_rs keep their last value after HOLD and change only at the next capture.
- Timer: one down-counter of width $clog2(max of all T_* + 1).
  - Entering a timed state loads T-1; the state exits when the counter is 0.
  - Every timed state therefore lasts exactly T cycles.
  - All T_* must be ≥1; a value of 0 is illegal and is checked with an assertion.
- Requests arriving while ready=0 are not accepted and not queued. The requester holds valid until it sees ready.
- Reset asserted mid-operation: all outputs go to their reset values immediately (asynchronously), including EN falling mid-pulse. The full power-up and init sequence reruns after release.

## Timing
- A capture at edge k puts new RS/DATA on the pins from cycle k+1.
- EN is high for cycles k+1+T_SETUP through k+T_SETUP+T_EN.
- o_req_ready returns to 1 at cycle k+1+T_SETUP+T_EN+T_HOLD+T_wait, where T_wait is T_EXEC or T_CLEAR.
- Back-to-back throughput is one byte per T_SETUP+T_EN+T_HOLD+T_wait+1 cycles, counting the 1 IDLE cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- lcd_pkg holds:
  - the state enum lcd_state_e;
  - the init ROM constants LCD_INIT_SEQ[4] and LCD_INIT_LEN;
  - the command codes CMD_CLEAR=8'h01, CMD_HOME=8'h02, FUNC_SET_8B2L=8'h38, DISP_ON=8'h0C, ENTRY_INC=8'h06.
- One sub-module, lcd_timer: a loadable down-counter with a load value input and a zero flag, shared by all timed states.

## Test plan
Benches use T_PWRUP=10, T_SETUP=2, T_EN=4, T_HOLD=2, T_EXEC=8, T_CLEAR=20.
- Reset release → o_lcd_on=1 after 1 edge; first EN rise 10+1+2 cycles later; EN pulses carry DATA 0x38, 0x0C, 0x01, 0x06 with RS=0; the gap after 0x01 is 20 cycles (others 8); then o_init_done=1 and o_req_ready=1.
- After init, a request with RS=1, DATA=0x41 accepted at edge k → pins show 0x41 and RS=1 from k+1; EN is high for exactly 4 cycles starting at k+3; ready returns at k+17.
- A request with RS=0, DATA=0x01 → EXEC_WAIT lasts 20 cycles; the same byte with RS=1 → 8 cycles.
- i_req_valid held high with changing data while busy → only the byte present in the ready cycle is written; no extra EN pulses; count exactly one pulse per handshake.
- i_reset asserted during EN_HIGH → EN drops in the same cycle without waiting for a clock; after release, o_init_done=0 and the 4-byte init sequence repeats.
